// File: rtl/mod_timing_counter_pkg.sv
// Shared constants and helpers for the symbol timing counter.
package timing_pkg;

    localparam logic [1:0] ADJ_NONE = 2'b00;
    localparam logic [1:0] ADJ_ADV  = 2'b01;
    localparam logic [1:0] ADJ_RET  = 2'b10;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int MOD_MAX_W = 32;

    // A programmed modulus of 0 selects the full 2^width range.
    function automatic logic [MOD_MAX_W:0] eff_mod(input logic [MOD_MAX_W-1:0] m,
                                                   input int unsigned width);
        logic [MOD_MAX_W:0] r;
        if (m == '0) begin
            r = {{MOD_MAX_W{1'b0}}, 1'b1} << width;
        end else begin
            r = {1'b0, m};
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_timing_counter_if.sv
// Control and status bundle between the timing counter and its user.
interface mod_timing_counter_if #(
    parameter int WIDTH = 8
);
    logic             en_sig;
    logic             clr_sig;
    logic             load_sig;
    logic [WIDTH-1:0] load_val_sig;
    logic [WIDTH-1:0] mod_sig;
    logic             dir_sig;
    logic [1:0]       adj_sig;
    logic [WIDTH-1:0] counter_sig;
    logic             tc_sig;
    logic             half_sig;

    modport master (
        output en_sig, clr_sig, load_sig, load_val_sig, mod_sig, dir_sig, adj_sig,
        input  counter_sig, tc_sig, half_sig
    );

    modport slave (
        input  en_sig, clr_sig, load_sig, load_val_sig, mod_sig, dir_sig, adj_sig,
        output counter_sig, tc_sig, half_sig
    );
endinterface

// File: rtl/mod_timing_counter_step.sv
// Combinational modulo step: next count, wrap flag and centre-hit flag.
// Single conditional subtract/add of M; M=1 and out-of-range counts are special-cased.
module mod_step
    import timing_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH:0]   i_mod,
    input  logic             i_dir,
    input  logic [1:0]       i_step,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap,
    output logic             o_half
);
    localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH:0]   w_cur_ext;
    logic [WIDTH:0]   w_step_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_half_pt;
    logic [WIDTH-1:0] w_up_wrap;
    logic [WIDTH-1:0] w_dn_wrap;
    logic [WIDTH-1:0] w_last;
    logic             w_moving;

    assign w_cur_ext  = {1'b0, i_cur};
    assign w_step_ext = {{(WIDTH-1){1'b0}}, i_step};
    assign w_sum      = w_cur_ext + w_step_ext;
    assign w_diff     = w_cur_ext - w_step_ext;
    assign w_half_pt  = i_mod >> 1;
    assign w_up_wrap  = w_sum[WIDTH-1:0] - i_mod[WIDTH-1:0];
    assign w_dn_wrap  = w_diff[WIDTH-1:0] + i_mod[WIDTH-1:0];
    assign w_last     = i_mod[WIDTH-1:0] - ONE_W;
    assign w_moving   = (i_step != 2'd0);

    always_comb begin
        o_next = i_cur;
        o_wrap = 1'b0;
        if (!w_moving) begin
            o_next = i_cur;
        end else if (i_mod == ONE_X) begin
            o_next = '0;
            o_wrap = 1'b1;
        end else if (w_cur_ext >= i_mod) begin
            // Count stranded above a freshly lowered modulus: snap to the boundary.
            o_next = (i_dir == DIR_DOWN) ? w_last : '0;
            o_wrap = 1'b1;
        end else if (i_dir == DIR_UP) begin
            if (w_sum >= i_mod) begin
                o_next = w_up_wrap;
                o_wrap = 1'b1;
            end else begin
                o_next = w_sum[WIDTH-1:0];
            end
        end else begin
            if (w_diff[WIDTH]) begin
                o_next = w_dn_wrap;
                o_wrap = 1'b1;
            end else begin
                o_next = w_diff[WIDTH-1:0];
            end
        end
    end

    assign o_half = w_moving && ({1'b0, o_next} == w_half_pt);

endmodule

// File: rtl/mod_timing_counter.sv
// Programmable-modulus symbol timing counter with phase nudge and tc/half strobes.
// All outputs registered, one edge after the sampled inputs; no backpressure.
module mod_timing_counter
    import timing_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int RST_VAL = 0
) (
    input  logic                 clk_sig,
    input  logic                 reset_sig,
    mod_timing_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_counter;
    logic             r_tc;
    logic             r_half;

    logic [WIDTH:0]   w_mod;
    logic [WIDTH-1:0] w_mod_last;
    logic [WIDTH-1:0] w_load;
    logic [1:0]       w_step;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;
    logic             w_half;

    assign w_mod      = (WIDTH+1)'(eff_mod(MOD_MAX_W'(bus.mod_sig), WIDTH));
    assign w_mod_last = w_mod[WIDTH-1:0] - ONE_W;
    assign w_load     = ({1'b0, bus.load_val_sig} >= w_mod) ? w_mod_last : bus.load_val_sig;

    always_comb begin
        w_step = 2'd1;
        case (bus.adj_sig)
            ADJ_NONE: w_step = 2'd1;
            ADJ_ADV:  w_step = 2'd2;
            ADJ_RET:  w_step = 2'd0;
            default:  w_step = 2'd1;
        endcase
    end

    mod_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_cur  (r_counter),
        .i_mod  (w_mod),
        .i_dir  (bus.dir_sig),
        .i_step (w_step),
        .o_next (w_next),
        .o_wrap (w_wrap),
        .o_half (w_half)
    );

    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            r_counter <= WIDTH'(RST_VAL);
            r_tc      <= 1'b0;
            r_half    <= 1'b0;
        end else begin
            r_tc   <= 1'b0;
            r_half <= 1'b0;
            if (bus.clr_sig) begin
                r_counter <= '0;
            end else if (bus.load_sig) begin
                r_counter <= w_load;
            end else if (bus.en_sig) begin
                r_counter <= w_next;
                r_tc      <= w_wrap;
                r_half    <= w_half;
            end
        end
    end

    assign bus.counter_sig = r_counter;
    assign bus.tc_sig      = r_tc;
    assign bus.half_sig    = r_half;

endmodule

// File: doc/mod_timing_counter.md
Name: mod_timing_counter

Overview:
Parametrised successor to the plain free-running counter, used as the sample/symbol timing source in the BPSK chain.
- Modulus is programmable at run time.
- Counts up or down, with enable, synchronous clear and synchronous load.
- Accepts one-sample advance/retard phase nudges from timing recovery.
- Emits registered terminal-count and mid-count strobes that mark the symbol boundary and the symbol centre.

Parameters:
- WIDTH, 8, counter width in bits.
- RST_VAL, 0, counter_sig value on reset; must be < 2^WIDTH.

Ports:
- clk_sig  input  1  system clock, rising edge.
- reset_sig  input  1  asynchronous, active-high reset.
- en_sig  input  1  count enable; one step per enabled cycle.
- clr_sig  input  1  synchronous clear to 0.
- load_sig  input  1  synchronous load of load_val_sig.
- load_val_sig  input  WIDTH  load value.
- mod_sig  input  WIDTH  modulus M; 0 means 2^WIDTH.
- dir_sig  input  1  0 = up, 1 = down.
- adj_sig  input  2  phase adjust: 00 none, 01 advance, 10 retard, 11 none.
- counter_sig  output  WIDTH  current count, range 0..M-1.
- tc_sig  output  1  one-cycle pulse, aligned with the cycle counter_sig shows a wrapped value.
- half_sig  output  1  one-cycle pulse, aligned with counter_sig first showing M>>1 after a step.

Behaviour:
- Reset: asynchronous, active-high. Forces counter_sig=RST_VAL, tc_sig=0, half_sig=0 immediately, independent of clk_sig. Release is sampled on the next rising edge.
- Priority per edge: reset_sig > clr_sig > load_sig > en_sig.
- clr_sig: counter_sig=0, tc_sig=0, half_sig=0.
- load_sig: counter_sig = min(load_val_sig, M-1), tc_sig=0, half_sig=0.
- en_sig=0 and no clr/load: counter holds, tc_sig=0, half_sig=0.
- Step size when enabled: 1 normally; 2 if adj_sig=01 (advance); 0 if adj_sig=10 (retard).
- adj_sig is ignored when en_sig=0.
- Up step: next = (cur + step) mod M. Computed in WIDTH+1 bits, with a single conditional subtract of M.
- Down step: next = (cur - step) mod M, with a single conditional add of M.
- Wrap is a step that crosses the M-1 <-> 0 boundary. tc_sig=1 in the cycle counter_sig shows the post-wrap value; else 0.
- A retard step (step 0) never wraps and never asserts tc_sig or half_sig.
- half_sig=1 when a nonzero step lands on exactly M>>1.
  - An advance that jumps over M>>1 does not assert half_sig.
- M=1: counter stays 0; tc_sig=1 on every enabled nonzero step.
- M=0 behaves as M=2^WIDTH; natural modular wrap.
- mod_sig is used combinationally each cycle (no shadow register).
  - If cur >= M after a modulus change, an up step goes to 0 with tc_sig=1.
  - If cur >= M after a modulus change, a down step goes to M-1 with tc_sig=1.
  - Same rule for any step size except 0.
- Latency: counter_sig, tc_sig and half_sig are all registered; they reflect inputs sampled at the previous edge. There are no combinational input-to-output paths.
- dir_sig may change on any cycle; it takes effect on that cycle's step.

Decomposition:
- Shared package timing_pkg holds:
  - localparams ADJ_NONE=2'b00, ADJ_ADV=2'b01, ADJ_RET=2'b10.
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
  - A function giving the effective modulus (0 -> 2^WIDTH), returned as a WIDTH+1-bit value.
- One combinational sub-module, mod_step, computes next value, wrap flag and half-hit flag. Inputs: cur, M, dir, step.
- Top level holds the registers and the priority logic.

Test Plan (WIDTH=8):
- M=16, up, en held high from 0 for 32 cycles -> counter_sig 0..15,0..15. tc_sig high on both returns to 0; half_sig high at each 8.
- M=16, load 3, down, 5 enabled cycles -> 2,1,0,15,14; tc_sig high only at 15.
- M=16, up, counter at 15, adj_sig=01 -> counter 1, tc_sig=1. At 7 with adj 01 -> 9, half_sig stays 0.
- M=16, up, counter at 5, adj_sig=10 for 3 cycles -> holds 5, tc_sig=0, half_sig=0; then resumes 6.
- Counter at 12, mod_sig changed to 10, one up step -> 0 with tc_sig=1. Down variant -> 9 with tc_sig=1.
- reset_sig pulsed mid-cycle at count 9 (between edges) -> counter_sig=0, tc_sig=half_sig=0 before the next edge. clr_sig and load_sig asserted together -> 0. load 200 with M=16 -> 15.
